// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// Module  : game_pkg
// Brief   : Shared state encoding and popcount helper for the game supervisor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE              = 3'd0,
        ST_ACTIVATING        = 3'd1,
        ST_ACTIVATED         = 3'd2,
        ST_DETONATING        = 3'd3,
        ST_MISSION_FAILED    = 3'd4,
        ST_MISSION_SUCCESSED = 3'd5
    } state_e;

    localparam int c_POPCNT_W = 6;

    function automatic logic [c_POPCNT_W-1:0] popcount32(input logic [31:0] vec);
        logic [c_POPCNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {{(c_POPCNT_W-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_timer.sv
//------------------------------------------------------------------------------
// Module  : game_timer
// Brief   : Saturating seconds countdown with load, tick and optional strike
//           penalty (enabled by STRIKE_PENALTY_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_timer
    import game_pkg::*;
#(
    parameter int TIMER_W    = 10,
    parameter int TIMER_INIT = 300,
    parameter int PENALTY    = 30
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  run_i,
    input  logic                  tick_i,
    input  logic [c_POPCNT_W-1:0] strike_cnt_i,
    output logic [TIMER_W-1:0]    time_left_o,
    output logic                  expire_o
);

    logic [TIMER_W-1:0] time_q;
    logic [TIMER_W-1:0] time_d;
    logic [31:0]        w_dec;
    logic               w_expire;

    always_comb begin
        w_dec    = {31'd0, tick_i};
`ifdef STRIKE_PENALTY_EN
        w_dec    = w_dec + 32'(PENALTY) * {{(32-c_POPCNT_W){1'b0}}, strike_cnt_i};
`endif
        if (w_dec >= 32'(time_q)) begin
            time_d = '0;
        end else begin
            time_d = time_q - TIMER_W'(w_dec);
        end
        w_expire = tick_i && (time_q <= TIMER_W'(1));
`ifdef STRIKE_PENALTY_EN
        // A penalty that drains the clock detonates on the same edge.
        if ((strike_cnt_i != '0) && (time_d == '0)) begin
            w_expire = 1'b1;
        end
`endif
    end

`ifndef STRIKE_PENALTY_EN
    logic w_unused_penalty;
    assign w_unused_penalty = ^{strike_cnt_i, 32'(PENALTY)};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            time_q <= '0;
        end else if (load_i) begin
            time_q <= TIMER_W'(TIMER_INIT);
        end else if (run_i) begin
            time_q <= time_d;
        end
    end

    assign time_left_o = time_q;
    assign expire_o    = run_i && w_expire;

endmodule

`default_nettype wire

// File: rtl/game_supervisor.sv
//------------------------------------------------------------------------------
// Module  : game_supervisor
// Brief   : Bomb-game supervisor FSM: activation, countdown, strikes, solve
//           tracking and detonation. Optional macro: STRIKE_PENALTY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_supervisor
    import game_pkg::*;
#(
    parameter int NUM_MODULES = 5,
    parameter int MAX_STRIKES = 3,
    parameter int TIMER_W     = 10,
    parameter int TIMER_INIT  = 300,
    parameter int DET_CYCLES  = 16,
    parameter int PENALTY     = 30
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   activate,
    input  logic [NUM_MODULES-1:0] mod_activated,
    input  logic [NUM_MODULES-1:0] mod_solved,
    input  logic [NUM_MODULES-1:0] mod_strike,
    input  logic                   tick_1hz,
    input  logic                   explode,
    output logic [2:0]             current_state,
    output logic [TIMER_W-1:0]     time_left,
    output logic [3:0]             strikes,
    output logic [NUM_MODULES-1:0] solved_mask,
    output logic                   strike_pulse
);

    localparam int c_DET_W = (DET_CYCLES > 1) ? $clog2(DET_CYCLES) : 1;

    state_e                 state_q;
    logic [3:0]             strikes_q;
    logic [NUM_MODULES-1:0] solved_q;
    logic                   strike_pulse_q;
    logic [c_DET_W-1:0]     det_cnt_q;

    logic                   w_active;
    logic                   w_load;
    logic [31:0]            w_strike_vec;
    logic [c_POPCNT_W-1:0]  w_strike_cnt;
    logic [6:0]             w_strike_sum;
    logic [3:0]             w_strikes_sat;
    logic                   w_timer_expire;
    logic                   w_boom;
    logic                   w_all_solved;

    always_comb begin
        w_active                       = (state_q == ST_ACTIVATED);
        w_load                         = (state_q == ST_ACTIVATING) && (&mod_activated);
        w_strike_vec                   = '0;
        w_strike_vec[NUM_MODULES-1:0]  = mod_strike;
        w_strike_cnt                   = w_active ? popcount32(w_strike_vec) : '0;
        w_strike_sum                   = 7'(strikes_q) + 7'(w_strike_cnt);
        w_strikes_sat                  = (w_strike_sum >= 7'(MAX_STRIKES)) ?
                                         4'(MAX_STRIKES) : w_strike_sum[3:0];
        w_boom                         = explode || w_timer_expire ||
                                         (w_strike_sum >= 7'(MAX_STRIKES));
        w_all_solved                   = &(solved_q | mod_solved);
    end

    game_timer #(
        .TIMER_W    (TIMER_W),
        .TIMER_INIT (TIMER_INIT),
        .PENALTY    (PENALTY)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (w_load),
        .run_i        (w_active),
        .tick_i       (tick_1hz && w_active),
        .strike_cnt_i (w_strike_cnt),
        .time_left_o  (time_left),
        .expire_o     (w_timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            strikes_q      <= '0;
            solved_q       <= '0;
            strike_pulse_q <= 1'b0;
            det_cnt_q      <= '0;
        end else begin
            strike_pulse_q <= w_active && (|mod_strike);
            case (state_q)
                ST_IDLE: begin
                    if (!activate) begin
                        state_q <= ST_ACTIVATING;
                    end
                end
                ST_ACTIVATING: begin
                    if (&mod_activated) begin
                        state_q   <= ST_ACTIVATED;
                        strikes_q <= '0;
                        solved_q  <= '0;
                    end
                end
                ST_ACTIVATED: begin
                    strikes_q <= w_strikes_sat;
                    solved_q  <= solved_q | mod_solved;
                    det_cnt_q <= '0;
                    // Detonation has priority over a simultaneous final solve.
                    if (w_boom) begin
                        state_q <= ST_DETONATING;
                    end else if (w_all_solved) begin
                        state_q <= ST_MISSION_SUCCESSED;
                    end
                end
                ST_DETONATING: begin
                    if (det_cnt_q == c_DET_W'(DET_CYCLES - 1)) begin
                        state_q <= ST_MISSION_FAILED;
                    end else begin
                        det_cnt_q <= det_cnt_q + c_DET_W'(1);
                    end
                end
                ST_MISSION_FAILED, ST_MISSION_SUCCESSED: begin
                    state_q <= state_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign current_state = state_q;
    assign strikes       = strikes_q;
    assign solved_mask   = solved_q;
    assign strike_pulse  = strike_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_game_supervisor.sv
//------------------------------------------------------------------------------
// Module  : tb_game_supervisor
// Brief   : Directed self-checking bench for game_supervisor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_supervisor;

`ifdef STRIKE_PENALTY_EN
    localparam int c_MAIN_PENALTY = 0;
`else
    localparam int c_MAIN_PENALTY = 30;
`endif

    logic       clk;
    logic       rst;
    logic       activate;
    logic [3:0] mod_act;
    logic [3:0] mod_sol;
    logic [3:0] mod_str;
    logic       tick;
    logic       explode;
    logic [2:0] st;
    logic [9:0] tl;
    logic [3:0] sk;
    logic [3:0] sm;
    logic       sp;

    int checks   = 0;
    int failures = 0;

    game_supervisor #(
        .NUM_MODULES (4),
        .MAX_STRIKES (3),
        .TIMER_W     (10),
        .TIMER_INIT  (5),
        .DET_CYCLES  (16),
        .PENALTY     (c_MAIN_PENALTY)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .activate      (activate),
        .mod_activated (mod_act),
        .mod_solved    (mod_sol),
        .mod_strike    (mod_str),
        .tick_1hz      (tick),
        .explode       (explode),
        .current_state (st),
        .time_left     (tl),
        .strikes       (sk),
        .solved_mask   (sm),
        .strike_pulse  (sp)
    );

`ifdef STRIKE_PENALTY_EN
    logic       p_rst;
    logic       p_activate;
    logic [3:0] p_mod_act;
    logic [3:0] p_mod_str;
    logic [2:0] p_st;
    logic [9:0] p_tl;
    logic [3:0] p_sk;
    logic [3:0] p_sm;
    logic       p_sp;

    game_supervisor #(
        .NUM_MODULES (4),
        .MAX_STRIKES (3),
        .TIMER_W     (10),
        .TIMER_INIT  (40),
        .DET_CYCLES  (16),
        .PENALTY     (30)
    ) u_pen (
        .clk           (clk),
        .rst           (p_rst),
        .activate      (p_activate),
        .mod_activated (p_mod_act),
        .mod_solved    (4'b0000),
        .mod_strike    (p_mod_str),
        .tick_1hz      (1'b0),
        .explode       (1'b0),
        .current_state (p_st),
        .time_left     (p_tl),
        .strikes       (p_sk),
        .solved_mask   (p_sm),
        .strike_pulse  (p_sp)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic bring_up(input string tag);
        activate = 1'b0;
        step();
        activate = 1'b1;
        mod_act  = 4'b1111;
        step();
        mod_act  = 4'b0000;
        chk({tag, "_state"}, st, 3'd2);
        chk({tag, "_time"},  tl, 10'd5);
    endtask

    initial begin
        rst      = 1'b0;
        activate = 1'b1;
        mod_act  = '0;
        mod_sol  = '0;
        mod_str  = '0;
        tick     = 1'b0;
        explode  = 1'b0;
`ifdef STRIKE_PENALTY_EN
        p_rst      = 1'b0;
        p_activate = 1'b1;
        p_mod_act  = '0;
        p_mod_str  = '0;
`endif
        step();
        step();
        chk("rst_state",   st, 3'd0);
        chk("rst_time",    tl, 10'd0);
        chk("rst_strikes", sk, 4'd0);
        chk("rst_mask",    sm, 4'd0);
        chk("rst_pulse",   sp, 1'b0);
        rst = 1'b1;
        step();
        chk("idle_hold", st, 3'd0);

        // Activation handshake and countdown to detonation
        activate = 1'b0;
        step();
        activate = 1'b1;
        chk("to_activating", st, 3'd1);
        mod_act = 4'b1011;
        step();
        chk("partial_ready", st, 3'd1);
        mod_act = 4'b1111;
        step();
        mod_act = 4'b0000;
        chk("to_activated", st, 3'd2);
        chk("load_time",    tl, 10'd5);
        for (int i = 1; i <= 4; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk("tick_time",  tl, 32'(5 - i));
            chk("tick_state", st, 3'd2);
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("timeout_det", st, 3'd3);
        for (int i = 0; i < 15; i++) step();
        chk("det_last_cycle", st, 3'd3);
        step();
        chk("to_failed",   st, 3'd4);
        chk("failed_time", tl, 10'd0);
        tick    = 1'b1;
        mod_str = 4'b0001;
        step();
        tick    = 1'b0;
        mod_str = 4'b0000;
        chk("failed_hold",    st, 3'd4);
        chk("failed_strikes", sk, 4'd0);
        chk("failed_pulse",   sp, 1'b0);

        // Strike accumulation to MAX_STRIKES
        do_reset();
        bring_up("strk_up");
        mod_str = 4'b0011;
        step();
        mod_str = 4'b0000;
        chk("strike2_cnt",   sk, 4'd2);
        chk("strike2_pulse", sp, 1'b1);
        chk("strike2_state", st, 3'd2);
        chk("strike2_time",  tl, 10'd5);
        step();
        chk("strike2_pulse_off", sp, 1'b0);
        mod_str = 4'b0100;
        step();
        mod_str = 4'b0000;
        chk("strike3_cnt",   sk, 4'd3);
        chk("strike3_pulse", sp, 1'b1);
        chk("strike3_state", st, 3'd3);
        step();
        chk("strike3_pulse_off", sp, 1'b0);

        // All modules solved one at a time
        do_reset();
        bring_up("solve_up");
        mod_sol = 4'b0001;
        step();
        mod_sol = 4'b0010;
        step();
        mod_sol = 4'b0100;
        step();
        mod_sol = 4'b0000;
        chk("solve_partial_mask",  sm, 4'b0111);
        chk("solve_partial_state", st, 3'd2);
        mod_sol = 4'b1000;
        step();
        mod_sol = 4'b0000;
        chk("solve_mask",  sm, 4'b1111);
        chk("solve_state", st, 3'd5);
        tick    = 1'b1;
        mod_str = 4'b0001;
        step();
        tick    = 1'b0;
        mod_str = 4'b0000;
        chk("success_hold",    st, 3'd5);
        chk("success_time",    tl, 10'd5);
        chk("success_strikes", sk, 4'd0);

        // Final solve coinciding with explode: detonation wins
        do_reset();
        bring_up("tie_up");
        mod_sol = 4'b0001;
        step();
        mod_sol = 4'b0010;
        step();
        mod_sol = 4'b0100;
        step();
        mod_sol = 4'b1000;
        explode = 1'b1;
        step();
        mod_sol = 4'b0000;
        explode = 1'b0;
        chk("tie_state", st, 3'd3);

        // Reset during detonation
        do_reset();
        chk("post_rst_state", st, 3'd0);
        bring_up("rstdet_up");
        mod_str = 4'b0001;
        step();
        mod_str = 4'b0000;
        explode = 1'b1;
        step();
        explode = 1'b0;
        chk("det_cycle1", st, 3'd3);
        step();
        step();
        chk("det_cycle3", st, 3'd3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_det_rst_state",   st, 3'd0);
        chk("mid_det_rst_time",    tl, 10'd0);
        chk("mid_det_rst_strikes", sk, 4'd0);
        chk("mid_det_rst_mask",    sm, 4'd0);
        chk("mid_det_rst_pulse",   sp, 1'b0);

`ifdef STRIKE_PENALTY_EN
        // Strike penalty drains the clock
        p_rst = 1'b1;
        p_activate = 1'b0;
        step();
        p_activate = 1'b1;
        p_mod_act  = 4'b1111;
        step();
        p_mod_act  = 4'b0000;
        chk("pen_load",  p_tl, 10'd40);
        chk("pen_state", p_st, 3'd2);
        p_mod_str = 4'b0001;
        step();
        p_mod_str = 4'b0000;
        chk("pen_time1",  p_tl, 10'd10);
        chk("pen_state1", p_st, 3'd2);
        p_mod_str = 4'b0010;
        step();
        p_mod_str = 4'b0000;
        chk("pen_time2",  p_tl, 10'd0);
        chk("pen_state2", p_st, 3'd3);
        chk("pen_strikes", p_sk, 4'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_supervisor.md
GAME_SUPERVISOR -- requirements
Module: game_supervisor

Interface
REQ-001 SHALL have parameter NUM_MODULES, default 5, number of puzzle modules supervised.
REQ-002 SHALL have parameter MAX_STRIKES, default 3, strike count that causes detonation (range 1..15).
REQ-003 SHALL have parameter TIMER_W, default 10, width of countdown in seconds.
REQ-004 SHALL have parameter TIMER_INIT, default 300, countdown load value in seconds (nonzero, fits TIMER_W).
REQ-005 SHALL have parameter DET_CYCLES, default 16, clock cycles spent in DETONATING.
REQ-006 SHALL have parameter PENALTY, default 30, seconds removed per strike when STRIKE_PENALTY_EN is defined.
REQ-007 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-008 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-009 SHALL have port activate, input, 1, active-low start button level.
REQ-010 SHALL have port mod_activated, input, NUM_MODULES, per-module ready level.
REQ-011 SHALL have port mod_solved, input, NUM_MODULES, per-module solved pulse or level.
REQ-012 SHALL have port mod_strike, input, NUM_MODULES, per-module one-cycle wrong-answer pulse.
REQ-013 SHALL have port tick_1hz, input, 1, one-cycle seconds strobe.
REQ-014 SHALL have port explode, input, 1, external immediate detonation request.
REQ-015 SHALL have port current_state, output, 3, registered FSM state.
REQ-016 SHALL have port time_left, output, TIMER_W, remaining seconds.
REQ-017 SHALL have port strikes, output, 4, accumulated strikes, saturating at MAX_STRIKES.
REQ-018 SHALL have port solved_mask, output, NUM_MODULES, sticky per-module solved flags.
REQ-019 SHALL have port strike_pulse, output, 1, registered one-cycle pulse, one cycle after any strike is accepted.

Function
REQ-020 SHALL encode states IDLE=0, ACTIVATING=1, ACTIVATED=2, DETONATING=3, MISSION_FAILED=4, MISSION_SUCCESSED=5; codes 6-7 SHALL return to IDLE on the next cycle.
REQ-021 SHALL move IDLE->ACTIVATING on the first clock edge where activate==0.
REQ-022 SHALL move ACTIVATING->ACTIVATED when &mod_activated==1, and on that edge load time_left=TIMER_INIT and clear strikes and solved_mask.
REQ-023 SHALL, in ACTIVATED only, decrement time_left by 1 on each tick_1hz, saturating at 0.
REQ-024 SHALL, in ACTIVATED only, add popcount(mod_strike) to strikes in one cycle, saturating at MAX_STRIKES.
REQ-025 SHALL, in ACTIVATED only, OR mod_solved into solved_mask; inputs SHALL be ignored in all other states.
REQ-026 SHALL move ACTIVATED->DETONATING when explode, when tick_1hz arrives with time_left==1 or 0, or when the updated strikes reaches MAX_STRIKES.
REQ-027 SHALL move ACTIVATED->MISSION_SUCCESSED when (solved_mask|mod_solved) is all ones and no REQ-026 condition holds in the same cycle; detonation wins ties.
REQ-028 SHALL hold DETONATING for exactly DET_CYCLES cycles, then enter MISSION_FAILED.
REQ-029 SHALL keep MISSION_FAILED and MISSION_SUCCESSED terminal until reset; time_left, strikes and solved_mask SHALL freeze there.

Reset
REQ-030 SHALL, when rst==0 at a clock edge, set current_state=IDLE, time_left=0, strikes=0, solved_mask=0, strike_pulse=0 and clear the detonation counter; this applies in any state, including mid-DETONATING.

Configuration
REQ-031 SHALL, with STRIKE_PENALTY_EN defined, subtract PENALTY*popcount(mod_strike) from time_left, saturating at 0; a result of 0 SHALL trigger DETONATING on the same edge.
REQ-032 SHALL, without STRIKE_PENALTY_EN, leave time_left unaffected by strikes.

Structure
REQ-033 SHALL take the state encoding constants from the shared package game_pkg.
REQ-034 SHALL implement the countdown, covering load, tick, penalty and saturation, in sub-module game_timer.

Verification
REQ-035 SHALL cover: NUM_MODULES=4, TIMER_INIT=5, activate=0, mod_activated=4'b1111 -> states 0->1->2, time_left=5.
REQ-036 SHALL cover: 5 tick_1hz in ACTIVATED -> time_left 4,3,2,1, then DETONATING, then MISSION_FAILED after 16 cycles.
REQ-037 SHALL cover: mod_strike=4'b0011 then 4'b0100 with MAX_STRIKES=3 -> strikes 2, then 3 and DETONATING; strike_pulse high once after each.
REQ-038 SHALL cover: mod_solved pulses 1,2,4,8 on separate cycles -> solved_mask=4'b1111 and MISSION_SUCCESSED; final pulse with explode=1 in the same cycle -> DETONATING instead.
REQ-039 SHALL cover: rst=0 on cycle 3 of DETONATING -> IDLE next edge with all outputs 0.
REQ-040 SHALL cover: STRIKE_PENALTY_EN defined, PENALTY=30, time_left=40, one strike -> time_left=10; a second strike -> 0 and DETONATING.
